col_scan_ctrl: RTL and testbench

Sequencer for the column clock-enable divider. Latches a scan configuration on start, programs the divider's half-period ratio and holds it in reset between scans. Detects rising edges of the divider's enable output and steps a column index 0..NUM_COL-1 for a programmed number of frames. Sits between the SPI register block / command FSM (st_main_work) and the pixel column readout.

---
 rtl/col_scan_ctrl_pkg.sv | 24 ++
 rtl/col_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_col_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/col_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// col_scan_ctrl_pkg
// Shared constants and state encoding for the column scan sequencer.
//   NUM_COL : columns per frame
//   CNT_COL : column index width (clog2 of NUM_COL)
//   RATIO_W : divider half-period ratio width
//   FRAME_W : frame counter width
// ----------------------------------------------------------------------------
package col_scan_ctrl_pkg;

    localparam int NUM_COL = 16;
    localparam int CNT_COL = 4;
    localparam int RATIO_W = 16;
    localparam int FRAME_W = 8;

    // ST_DONE lasts exactly one cycle and then returns to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } scan_state_e;

endpackage

// File: rtl/col_scan_ctrl.sv
// ----------------------------------------------------------------------------
// col_scan_ctrl
// Sequencer for the column clock-enable divider. On start it latches the scan
// configuration, releases the divider with the programmed half-period ratio,
// then steps a column index on every rising edge of the divider enable for
// the programmed number of frames (0 = run until abort).
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle scan request
//   abort          in   one-cycle scan cancel
//   cfg_ratio      in   divider ratio, half-period = cfg_ratio+1 clocks
//   cfg_frames     in   frames per scan, 0 = continuous
//   div_clk_enable in   enable returned from the divider
//   div_ratio      out  ratio held for the divider during a scan
//   div_run_n      out  divider reset, low keeps the divider cleared
//   col_sel        out  current column index
//   col_flag       out  pulse on every column entry
//   frame_done     out  pulse after the last column of a frame
//   done           out  pulse at scan completion
//   busy           out  high in ARM/SCAN/DONE
//   err            out  pulse when start arrives while busy
// ----------------------------------------------------------------------------
module col_scan_ctrl
    import col_scan_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic [FRAME_W-1:0] cfg_frames,
    input  logic               div_clk_enable,
    output logic [RATIO_W-1:0] div_ratio,
    output logic               div_run_n,
    output logic [CNT_COL-1:0] col_sel,
    output logic               col_flag,
    output logic               frame_done,
    output logic               done,
    output logic               busy,
    output logic               err
);

    localparam logic [CNT_COL-1:0] LAST_COL = CNT_COL'(NUM_COL - 1);

    scan_state_e        state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [FRAME_W-1:0] frames_q, frames_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_COL-1:0] col_q, col_d;
    logic               run_n_q, run_n_d;
    logic               ce_q;
    logic               col_flag_q, col_flag_d;
    logic               frame_done_q, frame_done_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               rise;
    logic               busy_now;
    logic [FRAME_W-1:0] frame_next;

    // ce_q is the previous-cycle copy of the divider enable.
    assign rise       = div_clk_enable & ~ce_q;
    assign busy_now   = (state_q != ST_IDLE);
    // Wraps harmlessly in continuous mode, where frames_q is zero.
    assign frame_next = frame_cnt_q + FRAME_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ratio_q      <= '0;
            frames_q     <= '0;
            frame_cnt_q  <= '0;
            col_q        <= '0;
            run_n_q      <= 1'b0;
            ce_q         <= 1'b0;
            col_flag_q   <= 1'b0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ratio_q      <= ratio_d;
            frames_q     <= frames_d;
            frame_cnt_q  <= frame_cnt_d;
            col_q        <= col_d;
            run_n_q      <= run_n_d;
            ce_q         <= div_clk_enable;
            col_flag_q   <= col_flag_d;
            frame_done_q <= frame_done_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic. The configuration registers only load in IDLE, so
    // div_ratio stays fixed for the whole scan. Abort is applied last so it
    // overrides any rise-driven update in the same cycle.
    always_comb begin
        state_d      = state_q;
        ratio_d      = ratio_q;
        frames_d     = frames_q;
        frame_cnt_d  = frame_cnt_q;
        col_d        = col_q;
        run_n_d      = run_n_q;
        col_flag_d   = 1'b0;
        frame_done_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    ratio_d  = cfg_ratio;
                    frames_d = cfg_frames;
                    run_n_d  = 1'b1;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (rise) begin
                    col_d       = '0;
                    col_flag_d  = 1'b1;
                    frame_cnt_d = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (rise) begin
                    if (col_q != LAST_COL) begin
                        col_d      = col_q + CNT_COL'(1);
                        col_flag_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_next;
                        if ((frames_q != '0) && (frame_next == frames_q)) begin
                            state_d = ST_DONE;
                        end else begin
                            col_d      = '0;
                            col_flag_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                run_n_d = 1'b0;
                col_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (busy_now && abort) begin
            state_d      = ST_IDLE;
            run_n_d      = 1'b0;
            col_d        = '0;
            frame_cnt_d  = '0;
            col_flag_d   = 1'b0;
            frame_done_d = 1'b0;
            done_d       = 1'b0;
        end

        if (busy_now && start && !abort) begin
            err_d = 1'b1;
        end
    end

    assign div_ratio  = ratio_q;
    assign div_run_n  = run_n_q;
    assign col_sel    = col_q;
    assign col_flag   = col_flag_q;
    assign frame_done = frame_done_q;
    assign done       = done_q;
    assign busy       = busy_now;
    assign err        = err_q;

endmodule

// File: tb/tb_col_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_col_scan_ctrl
// Self-checking bench for col_scan_ctrl. A behavioural divider stub closes the
// div_run_n/div_ratio -> div_clk_enable loop. Expected outputs come from an
// arithmetic timeline model: rise k of the divider appears at offset
// (ratio+1)*(2k+1) after release, and its registered effect one cycle later.
// ----------------------------------------------------------------------------
module tb_col_scan_ctrl;
    import col_scan_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [RATIO_W-1:0] cfg_ratio;
    logic [FRAME_W-1:0] cfg_frames;
    logic               div_clk_enable;
    logic [RATIO_W-1:0] div_ratio;
    logic               div_run_n;
    logic [CNT_COL-1:0] col_sel;
    logic               col_flag;
    logic               frame_done;
    logic               done;
    logic               busy;
    logic               err;

    always #5 clk = ~clk;

    col_scan_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_ratio      (cfg_ratio),
        .cfg_frames     (cfg_frames),
        .div_clk_enable (div_clk_enable),
        .div_ratio      (div_ratio),
        .div_run_n      (div_run_n),
        .col_sel        (col_sel),
        .col_flag       (col_flag),
        .frame_done     (frame_done),
        .done           (done),
        .busy           (busy),
        .err            (err)
    );

    // Divider stub: toggles its enable every div_ratio+1 clocks while released.
    logic [RATIO_W-1:0] divCnt;
    always_ff @(posedge clk) begin
        if (!div_run_n) begin
            divCnt         <= '0;
            div_clk_enable <= 1'b0;
        end else if (divCnt == div_ratio) begin
            divCnt         <= '0;
            div_clk_enable <= ~div_clk_enable;
        end else begin
            divCnt <= divCnt + RATIO_W'(1);
        end
    end

    typedef struct packed {
        logic               busy;
        logic               runN;
        logic [CNT_COL-1:0] col;
        logic               flag;
        logic               fdone;
        logic               done;
        logic               err;
        logic [RATIO_W-1:0] ratio;
    } obs_t;

    typedef struct {
        int ratio;
        int frames;
        int abortN;
        int startN;
        int expFlags;
        int expFd;
        int expDone;
    } vec_t;

    int                 errors = 0;
    int                 checks = 0;
    logic [RATIO_W-1:0] expRatio = '0;

    function automatic obs_t idleObs();
        obs_t e;
        e       = '0;
        e.ratio = expRatio;
        return e;
    endfunction

    // Expected outputs n cycles after the divider was released, for a scan
    // with ratio r and f frames (f = 0 means continuous).
    function automatic obs_t modelObs(int n, int r, int f);
        obs_t e;
        int   p;
        int   d;
        int   k;
        int   kEnd;
        int   tDone;
        e     = idleObs();
        p     = r + 1;
        kEnd  = (f == 0) ? 0 : NUM_COL * f;
        tDone = p * (2 * kEnd + 1) + 1;
        if (kEnd != 0 && n == tDone + 1) begin
            e.done = 1'b1;
            return e;
        end
        if (kEnd != 0 && n > tDone + 1) return e;
        e.busy = 1'b1;
        e.runN = 1'b1;
        d = n - 1 - p;
        if (d >= 0) begin
            k     = d / (2 * p);
            e.col = (kEnd != 0 && k >= kEnd) ? CNT_COL'(NUM_COL - 1) : CNT_COL'(k % NUM_COL);
            if (d % (2 * p) == 0) begin
                e.flag  = !(kEnd != 0 && k == kEnd);
                e.fdone = (k > 0) && (k % NUM_COL == 0);
            end
        end
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a,
                                 input logic [RATIO_W-1:0] r, input logic [FRAME_W-1:0] f);
        start      = s;
        abort      = a;
        cfg_ratio  = r;
        cfg_frames = f;
    endtask

    task automatic checkOutput(input string name, input obs_t e);
        obs_t act;
        act    = {busy, div_run_n, col_sel, col_flag, frame_done, done, err, div_ratio};
        checks = checks + 1;
        if (act !== e) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got busy=%0b run_n=%0b col=%0d flag=%0b fdone=%0b done=%0b err=%0b ratio=%0d, want busy=%0b run_n=%0b col=%0d flag=%0b fdone=%0b done=%0b err=%0b ratio=%0d",
                     name, act.busy, act.runN, act.col, act.flag, act.fdone, act.done, act.err, act.ratio,
                     e.busy, e.runN, e.col, e.flag, e.fdone, e.done, e.err, e.ratio);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Starts a scan and checks every cycle against the model. abortN/startN
    // inject abort or a rejected start at that offset; stopN ends the run early
    // without advancing past that cycle. Negative values disable each feature.
    task automatic runScan(input string tag, input int r, input int f, input int abortN,
                           input int startN, input int stopN,
                           output int nFlag, output int nFd, output int nDone);
        obs_t e;
        int   p;
        int   tDone;
        int   total;
        nFlag = 0;
        nFd   = 0;
        nDone = 0;
        applyStimulus(1'b1, 1'b0, RATIO_W'(r), FRAME_W'(f));
        cycle();
        expRatio = RATIO_W'(r);
        applyStimulus(1'b0, 1'b0, RATIO_W'($urandom), FRAME_W'($urandom));
        p     = r + 1;
        tDone = p * (2 * NUM_COL * f + 1) + 1;
        total = (abortN >= 0) ? abortN + 4 : tDone + 4;
        if (stopN >= 0) total = stopN + 1;
        for (int n = 0; n < total; n++) begin
            if (abortN >= 0 && n > abortN) e = idleObs();
            else                           e = modelObs(n, r, f);
            if (startN >= 0 && n == startN + 1) e.err = 1'b1;
            checkOutput($sformatf("%s n=%0d", tag, n), e);
            nFlag = nFlag + int'(col_flag);
            nFd   = nFd + int'(frame_done);
            nDone = nDone + int'(done);
            if (stopN >= 0 && n == total - 1) break;
            applyStimulus(n == startN, n == abortN,
                          (n == startN) ? RATIO_W'(9) : cfg_ratio, cfg_frames);
            cycle();
        end
        applyStimulus(1'b0, 1'b0, cfg_ratio, cfg_frames);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   nFlag;
        int   nFd;
        int   nDone;
        int   r;
        int   f;
        int   a;

        vecs[0] = '{ratio: 1, frames: 1, abortN: -1,  startN: -1, expFlags: 16, expFd: 1, expDone: 1};
        vecs[1] = '{ratio: 0, frames: 2, abortN: -1,  startN: -1, expFlags: 32, expFd: 2, expDone: 1};
        vecs[2] = '{ratio: 2, frames: 0, abortN: 34,  startN: -1, expFlags: 6,  expFd: 0, expDone: 0};
        vecs[3] = '{ratio: 1, frames: 1, abortN: -1,  startN: 20, expFlags: 16, expFd: 1, expDone: 1};
        vecs[4] = '{ratio: 3, frames: 0, abortN: 141, startN: -1, expFlags: 18, expFd: 1, expDone: 0};
        vecs[5] = '{ratio: 1, frames: 0, abortN: 14,  startN: -1, expFlags: 3,  expFd: 0, expDone: 0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("reset", idleObs());
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("idle after reset", idleObs());
        end

        // start and abort together in IDLE must be ignored entirely
        applyStimulus(1'b1, 1'b1, RATIO_W'(5), FRAME_W'(3));
        cycle();
        applyStimulus(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("start+abort in idle", idleObs());
            cycle();
        end

        for (int v = 0; v < 6; v++) begin
            runScan($sformatf("vec%0d", v), vecs[v].ratio, vecs[v].frames, vecs[v].abortN,
                    vecs[v].startN, -1, nFlag, nFd, nDone);
            checkCount($sformatf("vec%0d col_flag count", v), nFlag, vecs[v].expFlags);
            checkCount($sformatf("vec%0d frame_done count", v), nFd, vecs[v].expFd);
            checkCount($sformatf("vec%0d done count", v), nDone, vecs[v].expDone);
            cycle();
        end

        for (int it = 0; it < 6; it++) begin
            r = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                f = int'($urandom_range(1, 2));
                a = -1;
            end else begin
                f = 0;
                a = int'($urandom_range(2, 200));
            end
            runScan($sformatf("rand%0d r=%0d f=%0d a=%0d", it, r, f, a), r, f, a, -1, -1,
                    nFlag, nFd, nDone);
            cycle();
        end

        // Asynchronous reset while col_sel shows column 7
        runScan("pre-reset", 1, 1, -1, -1, 31, nFlag, nFd, nDone);
        #2;
        rst_n = 1'b0;
        #1;
        expRatio = '0;
        checkOutput("async reset mid-scan", idleObs());
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            checkOutput("idle after mid-scan reset", idleObs());
            cycle();
        end

        runScan("restart", 0, 1, -1, -1, -1, nFlag, nFd, nDone);
        checkCount("restart col_flag count", nFlag, 16);
        checkCount("restart done count", nDone, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
